// File: rtl/bcd_conv_sched.sv
// Two-requester binary-to-BCD converter.
// A round-robin arbiter picks one requester. A double-dabble engine then runs
// one iteration per clock and presents the packed BCD result with a
// done pulse for the requester that was served.
module bcd_conv_sched #(
    parameter int unsigned BIN_W  = 20,
    parameter int unsigned DIGITS = 7
) (
    input  logic                  Sys_CLK,
    input  logic                  Sys_RST,
    input  logic                  Req0,
    input  logic [BIN_W-1:0]      Bin0,
    input  logic                  Req1,
    input  logic [BIN_W-1:0]      Bin1,
    output logic                  Grant0,
    output logic                  Grant1,
    output logic                  Busy,
    output logic                  Done0,
    output logic                  Done1,
    output logic [4*DIGITS-1:0]   Data_BCD
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic               sel, sel_n;
    logic               last, last_n;
    logic [BIN_W-1:0]   opnd, opnd_n;
    logic [BCD_W-1:0]   acc, acc_n;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   shifted;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [BCD_W-1:0]   data_n;
    logic               grant0_n, grant1_n, busy_n, done0_n, done1_n;
    logic               win;

    // Add-3 correction applied to every digit of 5 or more before the shift.
    always_comb begin
        adj = acc;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[BCD_W-2:0], opnd[BIN_W-1]};
    end

    // Round-robin winner: the one that was not served last, on contention.
    always_comb begin
        win = 1'b0;
        if (Req0 && Req1) begin
            win = ~last;
        end else begin
            win = Req1;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state;
        sel_n    = sel;
        last_n   = last;
        opnd_n   = opnd;
        acc_n    = acc;
        cnt_n    = cnt;
        data_n   = Data_BCD;
        grant0_n = Grant0;
        grant1_n = Grant1;
        busy_n   = Busy;
        done0_n  = 1'b0;
        done1_n  = 1'b0;

        case (state)
            IDLE: begin
                if (Req0 || Req1) begin
                    sel_n    = win;
                    last_n   = win;
                    opnd_n   = win ? Bin1 : Bin0;
                    acc_n    = '0;
                    cnt_n    = '0;
                    grant0_n = ~win;
                    grant1_n = win;
                    busy_n   = 1'b1;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                acc_n  = shifted;
                opnd_n = {opnd[BIN_W-2:0], 1'b0};
                cnt_n  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    data_n  = shifted;
                    done0_n = ~sel;
                    done1_n = sel;
                    state_n = DONE;
                end
            end
            DONE: begin
                grant0_n = 1'b0;
                grant1_n = 1'b0;
                busy_n   = 1'b0;
                state_n  = IDLE;
            end
            default: begin
                grant0_n = 1'b0;
                grant1_n = 1'b0;
                busy_n   = 1'b0;
                state_n  = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset leaves requester 0 favoured.
    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            state    <= IDLE;
            sel      <= 1'b0;
            last     <= 1'b1;
            opnd     <= '0;
            acc      <= '0;
            cnt      <= '0;
            Data_BCD <= '0;
            Grant0   <= 1'b0;
            Grant1   <= 1'b0;
            Busy     <= 1'b0;
            Done0    <= 1'b0;
            Done1    <= 1'b0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            last     <= last_n;
            opnd     <= opnd_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            Data_BCD <= data_n;
            Grant0   <= grant0_n;
            Grant1   <= grant1_n;
            Busy     <= busy_n;
            Done0    <= done0_n;
            Done1    <= done1_n;
        end
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed bench for bcd_conv_sched: conversions, arbitration, reset abort.
module tb_bcd_conv_sched;

    localparam int unsigned BIN_W  = 20;
    localparam int unsigned DIGITS = 7;

    logic              clk;
    logic              rst;
    logic              req0, req1;
    logic [BIN_W-1:0]  bin0, bin1;
    logic              grant0, grant1, busy, done0, done1;
    logic [27:0]       data_bcd;

    int errors = 0;
    int checks = 0;

    bcd_conv_sched #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .Sys_CLK  (clk),
        .Sys_RST  (rst),
        .Req0     (req0),
        .Bin0     (bin0),
        .Req1     (req1),
        .Bin1     (bin1),
        .Grant0   (grant0),
        .Grant1   (grant1),
        .Busy     (busy),
        .Done0    (done0),
        .Done1    (done1),
        .Data_BCD (data_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a grant edge: waits for the done pulse and checks
    // latency, which requester was flagged, and the result.
    task automatic wait_done(input string tag, input int which, input logic [27:0] exp_data);
        int          n;
        logic [27:0] held;
        logic        moved;
        n     = 0;
        held  = data_bcd;
        moved = 1'b0;
        while (n < 60) begin
            tick();
            n++;
            if (done0 || done1) break;
            if (data_bcd !== held) moved = 1'b1;
        end
        chk({tag, "_latency"}, 32'(n), 32'(BIN_W));
        chk({tag, "_hold"}, 32'(moved), 32'd0);
        chk({tag, "_done0"}, 32'(done0), (which == 0) ? 32'd1 : 32'd0);
        chk({tag, "_done1"}, 32'(done1), (which == 1) ? 32'd1 : 32'd0);
        chk({tag, "_data"}, 32'(data_bcd), 32'(exp_data));
    endtask

    initial begin
        logic [1:0] who;
        logic       spurious;
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        bin0 = '0;
        bin1 = '0;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grants", 32'({grant1, grant0}), 32'd0);
        chk("rst_dones", 32'({done1, done0}), 32'd0);
        chk("rst_data", 32'(data_bcd), 32'd0);
        #9 rst = 1'b0;

        // Requester 0, operand 19; request dropped during the conversion.
        req0 = 1'b1;
        bin0 = 20'd19;
        tick();
        chk("c19_grant0", 32'(grant0), 32'd1);
        chk("c19_busy", 32'(busy), 32'd1);
        req0 = 1'b0;
        wait_done("c19", 0, 28'h0000019);
        chk("c19_grant_in_done", 32'(grant0), 32'd1);
        tick();
        chk("c19_idle", 32'({busy, grant1, grant0, done0}), 32'd0);

        // Requester 1, operand changed after the grant edge.
        req1 = 1'b1;
        bin1 = 20'd43508;
        tick();
        chk("c43508_grants", 32'({grant1, grant0}), 32'b10);
        bin1 = 20'd999;
        req1 = 1'b0;
        wait_done("c43508", 1, 28'h0043508);
        tick();

        // Extremes of the operand range.
        req0 = 1'b1;
        bin0 = 20'd1048575;
        tick();
        req0 = 1'b0;
        wait_done("cmax", 0, 28'h1048575);
        tick();
        req0 = 1'b1;
        bin0 = 20'd0;
        tick();
        req0 = 1'b0;
        wait_done("czero", 0, 28'h0000000);
        tick();

        // Fresh reset, then both requesting continuously: 0,1,0,1.
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        bin0 = 20'd12;
        bin1 = 20'd34;
        tick();
        for (int g = 0; g < 4; g++) begin
            who = (g % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("rr%0d_grant", g), 32'({grant1, grant0}), 32'(who));
            wait_done($sformatf("rr%0d", g), g % 2, (g % 2 == 0) ? 28'h12 : 28'h34);
            tick();
            chk($sformatf("rr%0d_idle", g), 32'(busy), 32'd0);
            tick();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        // The loop's last tick was the edge after an idle cycle with both
        // requests still high, so one more conversion (requester 0) started.
        chk("rr_extra_grant", 32'({grant1, grant0}), 32'b01);
        wait_done("rr_extra", 0, 28'h12);
        tick();

        // Reset in the middle of a conversion.
        req0 = 1'b1;
        bin0 = 20'd777;
        tick();
        for (int i = 0; i < 10; i++) tick();
        chk("abort_pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_grants", 32'({grant1, grant0}), 32'd0);
        chk("abort_dones", 32'({done1, done0}), 32'd0);
        chk("abort_data", 32'(data_bcd), 32'd0);
        req0 = 1'b0;
        #1 rst = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done0 || done1 || busy) spurious = 1'b1;
        end
        chk("abort_no_done", 32'(spurious), 32'd0);
        req0 = 1'b1;
        bin0 = 20'd5;
        tick();
        chk("post_abort_grant", 32'(grant0), 32'd1);
        req0 = 1'b0;
        wait_done("post_abort", 0, 28'h0000005);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_conv_sched.md
BCD_CONV_SCHED -- requirements
Module: bcd_conv_sched

Interface
REQ-001 Parameter BIN_W, default 20: binary operand width.
REQ-002 Parameter DIGITS, default 7: BCD digit count; BCD bus width is 4*DIGITS (28).
REQ-003 Sys_CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 Sys_RST  input  1  reset, asynchronous and active-high.
REQ-005 Req0  input  1  requester 0 conversion request, level.
REQ-006 Bin0  input  BIN_W  requester 0 binary operand.
REQ-007 Req1  input  1  requester 1 conversion request, level.
REQ-008 Bin1  input  BIN_W  requester 1 binary operand.
REQ-009 Grant0  output  1  high while requester 0's conversion is in progress.
REQ-010 Grant1  output  1  high while requester 1's conversion is in progress.
REQ-011 Busy  output  1  high in any state other than IDLE.
REQ-012 Done0  output  1  one-cycle pulse: requester 0 result valid on Data_BCD.
REQ-013 Done1  output  1  one-cycle pulse: requester 1 result valid on Data_BCD.
REQ-014 Data_BCD  output  4*DIGITS  packed BCD result; digit 0 is the least-significant nibble, in bits [3:0].

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-016 IDLE: on an edge with any Req high, the block SHALL grant one requester, latch that requester's Bin, clear the BCD accumulator and the iteration counter, and enter SHIFT.
REQ-017 Arbitration SHALL be round-robin:
- One requester high: that requester wins.
- Both high: the requester not granted last wins.
- After reset, the last-granted pointer SHALL favour requester 0.
REQ-018 SHIFT: each edge SHALL perform one double-dabble iteration:
- Add 3 to every BCD digit greater than or equal to 5.
- Then shift {BCD, operand} left by one bit.
REQ-019 After exactly BIN_W SHIFT edges, the block SHALL load Data_BCD with the accumulator and enter DONE.
REQ-020 DONE SHALL last one cycle and assert DoneX for the granted requester only, then return to IDLE.
REQ-021 Latency: if the grant edge is k, the corresponding DoneX SHALL be high between edges k+BIN_W and k+BIN_W+1; the next grant SHALL occur no earlier than edge k+BIN_W+2.
REQ-022 GrantX SHALL be high in both SHIFT and DONE for the granted requester.
REQ-023 BinX SHALL be sampled only on the grant edge; later changes SHALL NOT affect the running conversion.
REQ-024 Deasserting ReqX during SHIFT SHALL NOT abort the conversion; DoneX SHALL still pulse.
REQ-025 A ReqX still high when the FSM returns to IDLE SHALL be treated as a new request.
REQ-026 Data_BCD SHALL hold the last result until the next DONE state; it SHALL NOT change during SHIFT.
REQ-027 Every operand from 0 to 2^BIN_W-1 SHALL convert exactly; with the defaults, 1048575 fits in 7 digits, so no overflow case exists.
REQ-028 Done0 and Done1 SHALL never be high in the same cycle, and Grant0 and Grant1 SHALL never be high in the same cycle.

Reset
REQ-029 While Sys_RST is high, the block SHALL immediately force the following, regardless of the clock:
- State IDLE.
- Grant0, Grant1, Busy, Done0 and Done1 low.
- Data_BCD all zero.
- Accumulator and counter cleared.
- Last-granted pointer set so that requester 0 is favoured.
REQ-030 Reset asserted during SHIFT SHALL abort the conversion with no DoneX pulse; after reset is released, the block SHALL accept requests on the first edge.

Verification
REQ-031 Req0=1, Bin0=19 -> Done0 pulse 20 cycles after the grant edge, Data_BCD=28'h0000019, Done1 stays low.
REQ-032 Req1=1, Bin1=43508 -> Grant1 high, Data_BCD=28'h0043508 on Done1; Bin1 changed mid-conversion -> result unchanged.
REQ-033 Req0=1, Bin0=1048575 -> Data_BCD=28'h1048575; Bin0=0 -> Data_BCD=28'h0000000.
REQ-034 Req0=Req1=1 held continuously, Bin0=12, Bin1=34, first request after reset:
- Requester 0 is granted first.
- Grants then alternate 0,1,0,1, with Data_BCD alternating 0x12 and 0x34.
- Each grant is spaced BIN_W+2 cycles from the previous one.
REQ-035 Sys_RST pulsed between clock edges at SHIFT iteration 10:
- All outputs go low or zero without waiting for a clock edge.
- No Done pulse is produced.
- A new Req0 after release converts correctly.
